multicycle_cu: RTL and testbench
================================

// Module: multicycle_cu
// PURPOSE
//  Multi-cycle RV32I control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB over a shared-memory datapath.
//  Decodes the same opcode subset as the single-cycle controller (R add/sub/and/or/slt, addi/ori/slti, lw, sw, beq/bne, jal, jalr, lui).
//  Adds a memory ready handshake, optional blt/bge, an illegal-opcode trap and an instruction-retire pulse.
// PARAMETERS
//  ALUC_W        3  width of alu_ctrl; encodings zero-extended (add 0, sub 1, and 2, or 3, slt 5)
//  MEM_WAIT      1  1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready ignored, treated as 1
//  BRANCH_LT_EN  0  1: func3 100 (blt) and 101 (bge) decoded, using alu_lt; 0: they trap
//  TRAP_EN       1  1: unknown opcode/func -> sticky S_TRAP; 0: treated as NOP, return to FETCH
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  opcode      in   7       IR[6:0] (IR valid from DECODE onward)
//  func3       in   3       IR[14:12]
//  func7       in   7       IR[31:25]
//  zero        in   1       ALU result == 0
//  alu_lt      in   1       signed rs1 < rs2 from ALU
//  mem_ready   in   1       memory completed the access this cycle
//  pc_write    out  1       PC <= Result
//  adr_src     out  1       0: mem addr = PC; 1: mem addr = Result
//  mem_write   out  1       store strobe, held until mem_ready
//  ir_write    out  1       IR and OldPC load
//  reg_write   out  1       register-file write
//  result_src  out  2       00 ALUOut, 01 Data, 10 ALUResult, 11 Imm
//  alu_src_a   out  2       00 PC, 01 OldPC, 10 A (rs1)
//  alu_src_b   out  2       00 B (rs2), 01 Imm, 10 const 4
//  alu_ctrl    out  ALUC_W  ALU op
//  imm_src     out  3       000 I, 001 S, 010 B, 011 J, 100 U
//  state_o     out  4       current state (debug/coverage)
//  instr_done  out  1       1-cycle pulse in the last state of each instruction
//  illegal_op  out  1       high while in S_TRAP
// BEHAVIOUR
//  - Reset: state <= S_FETCH. While rst=1 every output is 0. All outputs are Moore (state) except pc_write in
//    BRANCH/FETCH and ir_write, which qualify on zero/alu_lt/mem_ready.
//  - Default for all outputs in every state is 0; imm_src is decoded from opcode in every state.
//  - FETCH: adr_src 0, src_a 00, src_b 10, add, result_src 10; ir_write = pc_write = mem_ready; -> DECODE on mem_ready, else stay.
//  - DECODE: src_a 01, src_b 01, add (branch/jal target into ALUOut). Next state by opcode: 3/35->MEMADR, 51->EXR,
//    19->EXI, 99->BRANCH, 111->JAL, 103->JALR, 55->LUI, else TRAP (or FETCH if TRAP_EN=0).
//  - MEMADR: src_a 10, src_b 01, add; -> MEMRD (lw) | MEMWR (sw).
//  - MEMRD: adr_src 1, result_src 00; -> MEMWB on mem_ready. MEMWB: result_src 01, reg_write; -> FETCH.
//  - MEMWR: adr_src 1, result_src 00, mem_write held high; -> FETCH on mem_ready (done pulse that cycle).
//  - EXR: src_a 10, src_b 00, alu_ctrl from {func7,func3}. EXI: src_a 10, src_b 01, alu_ctrl from func3. Both -> ALUWB.
//  - Unsupported func combination in EXR/EXI -> TRAP (TRAP_EN=1) else add.
//  - ALUWB: result_src 00, reg_write; -> FETCH.
//  - BRANCH: src_a 10, src_b 00, sub, result_src 00; pc_write = taken; -> FETCH.
//    taken: beq zero; bne !zero; blt alu_lt; bge !alu_lt.
//  - JAL: result_src 00, pc_write; -> LINK. JALR: src_a 10, src_b 01, add, result_src 10, pc_write; -> LINK.
//  - LINK: src_a 01, src_b 10, add, result_src 10, reg_write (rd = OldPC+4); -> FETCH.
//  - LUI: result_src 11, reg_write; -> FETCH.
//  - Cycle counts with zero wait: lw 5, sw/R/I/jal/jalr 4, beq/lui 3. Each mem_ready=0 cycle adds one.
//  - TRAP: all enables 0, illegal_op 1, stays until rst. instr_done high in MEMWB, MEMWR (on ready), ALUWB, BRANCH, LINK, LUI.
//  - Reset mid-instruction: outputs drop to 0 immediately (async); FSM restarts at FETCH, no partial write.
// STRUCTURE
//  - Package cu_pkg: state_t enum (FETCH 0 .. LINK 13, TRAP 15), ALU op codes, opcode constants, mux select constants.
//  - Sub-module alu_decoder (combinational: mode R/I/sub/add, func3, func7 -> alu_ctrl, illegal flag).
//  - Top holds only the state register, next-state logic and the output decode.
// TESTING
//  - lw with mem_ready low 2 cycles in FETCH and MEMRD: 9 cycles total; reg_write only in MEMWB with result_src 01.
//  - R-type sub (func7 0x20, func3 0): EXR alu_ctrl 001, ALUWB reg_write 1, instr_done at cycle 4.
//  - beq with zero=1, then zero=0: pc_write 1 then 0 in BRANCH; both return to FETCH after 3 cycles.
//  - jalr: JALR pc_write 1 with result_src 10; LINK reg_write 1 with src_a 01 and src_b 10; no reg_write in JALR.
//  - opcode 0x7F: illegal_op 1 from cycle 3 and held, all enables 0; with TRAP_EN=0 FSM returns to FETCH.
//  - rst asserted during MEMWR with mem_write 1: mem_write 0 in the same cycle; after release, state_o 0 and FETCH resumes.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
// Holds the FSM state encoding, the ALU op codes, the opcodes it
// recognises, the datapath mux select values and the immediate-format helper.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXR    = 4'd6,
        S_EXI    = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_LINK   = 4'd13,
        S_TRAP   = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_R   = 2'd2,
        MODE_I   = 2'd3
    } alu_mode_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [6:0] OP_LW   = 7'd3;
    localparam logic [6:0] OP_SW   = 7'd35;
    localparam logic [6:0] OP_R    = 7'd51;
    localparam logic [6:0] OP_I    = 7'd19;
    localparam logic [6:0] OP_BR   = 7'd99;
    localparam logic [6:0] OP_JAL  = 7'd111;
    localparam logic [6:0] OP_JALR = 7'd103;
    localparam logic [6:0] OP_LUI  = 7'd55;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format follows the opcode alone; R-type and unknown opcodes
    // fall back to the I format since nothing consumes the immediate then.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder.
// Ports: mode (fixed add, fixed sub, R-type or I-type decode), func3, func7
// in; alu_ctrl (zero-extended op code) and illegal (unsupported func
// combination, op falls back to add) out.
module alu_decoder
    import cu_pkg::*;
#(
    parameter int ALUC_W = 3
) (
    input  alu_mode_t         mode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    output logic [ALUC_W-1:0] alu_ctrl,
    output logic              illegal
);

    logic [2:0] op;

    always_comb begin
        op      = ALU_ADD;
        illegal = 1'b0;
        case (mode)
            MODE_ADD: op = ALU_ADD;
            MODE_SUB: op = ALU_SUB;
            MODE_R: begin
                case ({func7, func3})
                    {7'h00, 3'b000}: op = ALU_ADD;
                    {7'h20, 3'b000}: op = ALU_SUB;
                    {7'h00, 3'b111}: op = ALU_AND;
                    {7'h00, 3'b110}: op = ALU_OR;
                    {7'h00, 3'b010}: op = ALU_SLT;
                    default:         illegal = 1'b1;
                endcase
            end
            MODE_I: begin
                case (func3)
                    3'b000:  op = ALU_ADD;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            default: op = ALU_ADD;
        endcase
    end

    assign alu_ctrl = ALUC_W'(op);

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back over a shared-memory datapath.
// Ports: clk, rst (async, active high); instruction fields opcode/func3/func7;
// ALU flags zero/alu_lt; mem_ready handshake. Outputs are the datapath
// enables and mux selects, alu_ctrl, imm_src, state_o (debug), instr_done
// (retire pulse) and illegal_op (sticky trap indicator).
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int ALUC_W       = 3,
    parameter int MEM_WAIT     = 1,
    parameter int BRANCH_LT_EN = 0,
    parameter int TRAP_EN      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic              zero,
    input  logic              alu_lt,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUC_W-1:0] alu_ctrl,
    output logic [2:0]        imm_src,
    output logic [3:0]        state_o,
    output logic              instr_done,
    output logic              illegal_op
);

    state_t            state, state_nxt;
    alu_mode_t         mode;
    logic [ALUC_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              rdy, taken, br_legal;
    state_t            bad_state;

    assign rdy       = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign bad_state = (TRAP_EN != 0) ? S_TRAP : S_FETCH;

    always_comb begin
        case (state)
            S_EXR:    mode = MODE_R;
            S_EXI:    mode = MODE_I;
            S_BRANCH: mode = MODE_SUB;
            default:  mode = MODE_ADD;
        endcase
    end

    alu_decoder #(.ALUC_W(ALUC_W)) u_alu_decoder (
        .mode     (mode),
        .func3    (func3),
        .func7    (func7),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // blt/bge are only legal when the signed-compare flag is wired up.
    always_comb begin
        br_legal = 1'b0;
        taken    = 1'b0;
        case (func3)
            3'b000: begin br_legal = 1'b1; taken = zero; end
            3'b001: begin br_legal = 1'b1; taken = !zero; end
            3'b100: begin br_legal = (BRANCH_LT_EN != 0); taken = alu_lt; end
            3'b101: begin br_legal = (BRANCH_LT_EN != 0); taken = !alu_lt; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXR;
                    OP_I:         state_nxt = S_EXI;
                    OP_BR:        state_nxt = br_legal ? S_BRANCH : bad_state;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_JALR:      state_nxt = S_JALR;
                    OP_LUI:       state_nxt = S_LUI;
                    default:      state_nxt = bad_state;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) state_nxt = S_MEMWB;
            S_MEMWR:  if (rdy) state_nxt = S_FETCH;
            S_EXR, S_EXI:
                state_nxt = (dec_illegal && (TRAP_EN != 0)) ? S_TRAP : S_ALUWB;
            S_JAL, S_JALR: state_nxt = S_LINK;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Everything is forced low while rst is high, so a reset landing in the
    // middle of an access removes the strobe in the same cycle.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = rdy;
                pc_write   = rdy;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = rdy;
            end
            S_EXR: alu_src_a = SRCA_RS1;
            S_EXI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                pc_write   = taken;
                instr_done = 1'b1;
            end
            S_JAL: pc_write = 1'b1;
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
            end
            S_LINK: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_LUI: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: illegal_op = 1'b1;
            default: ;
        endcase
        if (rst) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign alu_ctrl = rst ? '0 : dec_ctrl;
    assign imm_src  = rst ? 3'b000 : imm_sel(opcode);
    assign state_o  = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic       zero, alu_lt, mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_ctrl, imm_src;
    logic [3:0] state_o;

    logic       pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, instr_done2, illegal_op2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2;
    logic [2:0] alu_ctrl2, imm_src2;
    logic [3:0] state_o2;

    multicycle_cu dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src), .state_o(state_o),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    // Second build: no wait states, blt/bge enabled, traps disabled.
    multicycle_cu #(.ALUC_W(3), .MEM_WAIT(0), .BRANCH_LT_EN(1), .TRAP_EN(0)) dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
        .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_ctrl(alu_ctrl2), .imm_src(imm_src2), .state_o(state_o2),
        .instr_done(instr_done2), .illegal_op(illegal_op2)
    );

    typedef struct packed {
        logic       pc_write, adr_src, mem_write, ir_write, reg_write;
        logic [1:0] result_src, alu_src_a, alu_src_b;
        logic [2:0] alu_ctrl, imm_src;
        logic [3:0] state;
        logic       instr_done, illegal_op;
    } out_t;

    out_t obs1, obs2;
    assign obs1 = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                   alu_src_b, alu_ctrl, imm_src, state_o, instr_done, illegal_op};
    assign obs2 = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, result_src2, alu_src_a2,
                   alu_src_b2, alu_ctrl2, imm_src2, state_o2, instr_done2, illegal_op2};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_at, n_rw;
    out_t eq[$];
    logic rq[$];

    // ---------------- reference model ----------------
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'd35:   return 3'd1;
            7'd99:   return 3'd2;
            7'd111:  return 3'd3;
            7'd55:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic out_t base(input int st, input logic [6:0] op);
        out_t o = '0;
        o.state   = 4'(st);
        o.imm_src = imm_of(op);
        return o;
    endfunction

    // ALU op for the supported register/immediate instructions, -1 if unsupported
    function automatic int r_op(input logic [6:0] f7, input logic [2:0] f3);
        if (f7 == 7'h00 && f3 == 3'd0) return 0;
        if (f7 == 7'h20 && f3 == 3'd0) return 1;
        if (f7 == 7'h00 && f3 == 3'd7) return 2;
        if (f7 == 7'h00 && f3 == 3'd6) return 3;
        if (f7 == 7'h00 && f3 == 3'd2) return 5;
        return -1;
    endfunction

    function automatic int i_op(input logic [2:0] f3);
        if (f3 == 3'd0) return 0;
        if (f3 == 3'd6) return 3;
        if (f3 == 3'd2) return 5;
        return -1;
    endfunction

    task automatic push(input out_t o, input logic r);
        eq.push_back(o);
        rq.push_back(r);
    endtask

    // Expected per-cycle outputs and the mem_ready stimulus for one instruction.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic lt, input int wf, input int wm,
                         input bit trap_en, input bit lt_en, input bit mem_wait);
        out_t o;
        int   code;
        bit   bad, legal, taken, go;
        eq.delete();
        rq.delete();
        bad = 0;
        for (int k = 0; k <= wf; k++) begin
            o = base(0, op);
            o.alu_src_b = 2; o.result_src = 2;
            go = !mem_wait || (k == wf);
            o.ir_write = go; o.pc_write = go;
            push(o, k == wf);
            if (go) break;
        end
        o = base(1, op); o.alu_src_a = 1; o.alu_src_b = 1;
        push(o, 1'($urandom_range(0, 1)));
        case (op)
            7'd3, 7'd35: begin
                o = base(2, op); o.alu_src_a = 2; o.alu_src_b = 1;
                push(o, 1'($urandom_range(0, 1)));
                for (int k = 0; k <= wm; k++) begin
                    go = !mem_wait || (k == wm);
                    o = base(op == 7'd3 ? 3 : 5, op); o.adr_src = 1;
                    if (op == 7'd35) begin o.mem_write = 1; o.instr_done = go; end
                    push(o, k == wm);
                    if (go) break;
                end
                if (op == 7'd3) begin
                    o = base(4, op); o.result_src = 1; o.reg_write = 1; o.instr_done = 1;
                    push(o, 1'($urandom_range(0, 1)));
                end
            end
            7'd51, 7'd19: begin
                code = (op == 7'd51) ? r_op(f7, f3) : i_op(f3);
                o = base(op == 7'd51 ? 6 : 7, op); o.alu_src_a = 2;
                o.alu_src_b = (op == 7'd51) ? 2'd0 : 2'd1;
                o.alu_ctrl = (code < 0) ? 3'd0 : 3'(code);
                push(o, 1'($urandom_range(0, 1)));
                if (code < 0 && trap_en) bad = 1;
                else begin
                    o = base(8, op); o.reg_write = 1; o.instr_done = 1;
                    push(o, 1'($urandom_range(0, 1)));
                end
            end
            7'd99: begin
                legal = (f3 == 0) || (f3 == 1) || (lt_en && (f3 == 4 || f3 == 5));
                taken = (f3 == 0) ? z : (f3 == 1) ? !z : (f3 == 4) ? lt : !lt;
                if (!legal) bad = trap_en;
                else begin
                    o = base(9, op); o.alu_src_a = 2; o.alu_ctrl = 1;
                    o.pc_write = taken; o.instr_done = 1;
                    push(o, 1'($urandom_range(0, 1)));
                end
            end
            7'd111, 7'd103: begin
                if (op == 7'd111) o = base(10, op);
                else begin
                    o = base(11, op); o.alu_src_a = 2; o.alu_src_b = 1; o.result_src = 2;
                end
                o.pc_write = 1;
                push(o, 1'($urandom_range(0, 1)));
                o = base(13, op); o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
                o.reg_write = 1; o.instr_done = 1;
                push(o, 1'($urandom_range(0, 1)));
            end
            7'd55: begin
                o = base(12, op); o.result_src = 3; o.reg_write = 1; o.instr_done = 1;
                push(o, 1'($urandom_range(0, 1)));
            end
            default: bad = trap_en;
        endcase
        if (bad)
            for (int k = 0; k < 4; k++) begin
                o = base(15, op); o.illegal_op = 1;
                push(o, 1'($urandom_range(0, 1)));
            end
    endtask

    // Entered and left right at a falling edge.
    task automatic run(input bit sel, input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input logic lt, input int n);
        out_t got;
        done_at = -1;
        n_rw = 0;
        for (int i = 0; i < n; i++) begin
            opcode = op; func3 = f3; func7 = f7; zero = z; alu_lt = lt; mem_ready = rq[i];
            #1;
            got = sel ? obs2 : obs1;
            n_cmp++;
            if (got !== eq[i]) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
                         name, i, got, got.state, eq[i], eq[i].state);
            end
            if (got.instr_done && done_at < 0) done_at = i;
            n_rw += int'(got.reg_write);
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input bit sel, input string name, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7, input logic z,
                            input logic lt, input int wf, input int wm);
        build(op, f3, f7, z, lt, wf, wm, !sel, sel, !sel);
        run(sel, name, op, f3, f7, z, lt, eq.size());
    endtask

    task automatic reset_dut(input bit sel);
        if (sel) rst2 = 1'b1; else rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        if (sel) rst2 = 1'b0; else rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; rst2 = 1'b1;
        opcode = 7'd35; func3 = 3'd2; func7 = 7'd0; zero = 1'b1; alu_lt = 1'b1; mem_ready = 1'b1;
        #2;
        n_cmp++;
        if (obs1 !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", obs1); end
        n_cmp++;
        if (obs2 !== '0) begin n_bad++; $display("FAIL reset_outputs2: got %h expected 0", obs2); end
        mem_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw_waits;
        do_instr(0, "lw_wait", 7'd3, 3'd2, 7'd0, 0, 0, 2, 2);
        n_cmp++;
        if (done_at !== 8) begin n_bad++; $display("FAIL lw_wait_done_cycle: got %0d expected 8", done_at); end
        n_cmp++;
        if (n_rw !== 1) begin n_bad++; $display("FAIL lw_wait_reg_writes: got %0d expected 1", n_rw); end
    endtask

    task automatic test_rsub;
        do_instr(0, "r_sub", 7'd51, 3'd0, 7'h20, 0, 0, 0, 0);
        n_cmp++;
        if (done_at !== 3) begin n_bad++; $display("FAIL r_sub_done_cycle: got %0d expected 3", done_at); end
    endtask

    task automatic test_beq;
        do_instr(0, "beq_taken", 7'd99, 3'd0, 7'd0, 1, 0, 0, 0);
        n_cmp++;
        if (done_at !== 2) begin n_bad++; $display("FAIL beq_done_cycle: got %0d expected 2", done_at); end
        do_instr(0, "beq_not_taken", 7'd99, 3'd0, 7'd0, 0, 0, 0, 0);
        do_instr(0, "bne_taken", 7'd99, 3'd1, 7'd0, 0, 0, 1, 0);
    endtask

    task automatic test_jalr;
        do_instr(0, "jalr", 7'd103, 3'd0, 7'd0, 0, 0, 0, 0);
        do_instr(0, "jal", 7'd111, 3'd0, 7'd0, 0, 0, 1, 0);
        do_instr(0, "lui", 7'd55, 3'd5, 7'd0, 0, 0, 0, 0);
        do_instr(0, "sw", 7'd35, 3'd2, 7'd0, 0, 0, 0, 1);
    endtask

    task automatic pick(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
        logic [6:0] ops [8] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd55};
        int r;
        r = int'($urandom_range(0, 9));
        op = (r < 8) ? ops[r] : 7'($urandom);
        f3 = 3'($urandom);
        r = int'($urandom_range(0, 3));
        f7 = (r == 0) ? 7'h20 : (r == 1) ? 7'($urandom) : 7'h00;
    endtask

    task automatic test_random(input bit sel, input int n);
        logic [6:0] op, f7;
        logic [2:0] f3;
        for (int i = 0; i < n; i++) begin
            pick(op, f3, f7);
            do_instr(sel, "random", op, f3, f7, 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if (eq[eq.size()-1].illegal_op) reset_dut(sel);
        end
    endtask

    task automatic test_trap;
        do_instr(0, "trap_7f", 7'h7F, 3'd0, 7'd0, 0, 0, 0, 0);
        n_cmp++;
        if (illegal_op !== 1'b1) begin n_bad++; $display("FAIL trap_held: got %b expected 1", illegal_op); end
        reset_dut(0);
        do_instr(0, "trap_blt", 7'd99, 3'd4, 7'd0, 0, 1, 0, 0);
        reset_dut(0);
        do_instr(0, "trap_rfunc", 7'd51, 3'd1, 7'd0, 0, 0, 0, 0);
        reset_dut(0);
    endtask

    task automatic test_reset_mid;
        build(7'd35, 3'd2, 7'd0, 0, 0, 0, 3, 1, 0, 1);
        run(0, "sw_before_reset", 7'd35, 3'd2, 7'd0, 0, 0, 4);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b1) begin n_bad++; $display("FAIL memwr_strobe: got %b expected 1", mem_write); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs1 !== '0) begin n_bad++; $display("FAIL async_reset_outputs: got %h expected 0", obs1); end
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 4'd0) begin n_bad++; $display("FAIL state_after_reset: got %0d expected 0", state_o); end
        @(negedge clk);
        do_instr(0, "lw_after_reset", 7'd3, 3'd2, 7'd0, 0, 0, 1, 0);
    endtask

    task automatic test_trap_disabled;
        rst = 1'b1;
        reset_dut(1);
        do_instr(1, "nop_7f", 7'h7F, 3'd0, 7'd0, 0, 0, 0, 0);
        n_cmp++;
        if (illegal_op2 !== 1'b0) begin n_bad++; $display("FAIL no_trap: got %b expected 0", illegal_op2); end
        do_instr(1, "lui_after_nop", 7'd55, 3'd0, 7'd0, 0, 0, 2, 0);
        do_instr(1, "blt_taken", 7'd99, 3'd4, 7'd0, 0, 1, 0, 0);
        do_instr(1, "bge_not_taken", 7'd99, 3'd5, 7'd0, 1, 1, 0, 0);
        do_instr(1, "r_bad_func_add", 7'd51, 3'd0, 7'h01, 0, 0, 0, 0);
        do_instr(1, "lw_no_wait", 7'd3, 3'd2, 7'd0, 0, 0, 2, 2);
        test_random(1, 25);
    endtask

    initial begin
        test_reset();
        test_lw_waits();
        test_rsub();
        test_beq();
        test_jalr();
        test_random(0, 40);
        test_trap();
        test_reset_mid();
        test_trap_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
